// File: rtl/gate_eval_pkg.sv
// Shared types and the round-robin pick function for the gate evaluator arbiter.
// Sized for the largest supported configuration (16 requesters).
package gate_eval_pkg;

    localparam int unsigned MAX_REQ  = 16;
    localparam int unsigned MAX_ID_W = 4;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Scan ptr, ptr+1, ... modulo nreq and return the first valid requester.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0]  valid,
        input logic [MAX_ID_W-1:0] ptr,
        input int unsigned         nreq
    );
        pick_t       res;
        int unsigned pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= nreq) pos = pos - nreq;
            if (k < nreq && !res.found && valid[pos[MAX_ID_W-1:0]]) begin
                res.found = 1'b1;
                res.idx   = pos[MAX_ID_W-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gate_eval_arbiter_rr.sv
// Round-robin arbiter: one-hot grant and index of the first valid requester at or after ptr.
module rr_arbiter
    import gate_eval_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    pick_t pick;

    always_comb begin
        pick  = rr_pick(MAX_REQ'(valid), MAX_ID_W'(ptr), NREQ);
        idx   = ID_W'(pick.idx);
        grant = '0;
        if (pick.found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/gate_wire2.sv
// Shared combinational gate cell: y = (a | b) ^ (~b & c).
module gate_wire2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    always_comb begin
        y = (a | b) ^ (~b & c);
    end

endmodule

// File: rtl/gate_eval_arbiter.sv
// Round-robin arbitration of NREQ requesters onto one shared gate_wire2 evaluator,
// with a single registered, backpressured response stage tagged by requester index.
module gate_eval_arbiter
    import gate_eval_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = $clog2(NREQ),
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [3*NREQ-1:0]   req_abc,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_y,
    output logic [ID_W-1:0]     rsp_id,
    output logic [CNT_W-1:0]    txn_cnt
);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] win_idx;
    logic [2:0]      win_abc;
    logic            can_accept;
    logic            accept;
    logic            eval_y;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_comb begin
        rsp_valid  = (state == FULL);
        can_accept = !rsp_valid || rsp_ready;
        req_ready  = can_accept ? grant : '0;
        accept     = |(req_valid & req_ready);
        win_abc    = req_abc[3*win_idx +: 3];
    end

    gate_wire2 u_eval (
        .a (win_abc[2]),
        .b (win_abc[1]),
        .c (win_abc[0]),
        .y (eval_y)
    );

    // ptr moves only on accept, so a stalled winner keeps top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            rsp_y   <= 1'b0;
            rsp_id  <= '0;
            ptr     <= '0;
            txn_cnt <= '0;
        end else if (accept) begin
            state   <= FULL;
            rsp_y   <= eval_y;
            rsp_id  <= win_idx;
            ptr     <= (win_idx == ID_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            txn_cnt <= txn_cnt + 1'b1;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_gate_eval_arbiter.sv
// Randomized self-checking bench for gate_eval_arbiter against a transaction-level model.
`timescale 1ns/1ps
module tb_gate_eval_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned CNT_W = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [3*NREQ-1:0]   req_abc;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_y;
    logic [ID_W-1:0]     rsp_id;
    logic [CNT_W-1:0]    txn_cnt;
    logic [19:0]         rsp_word;

    int vectors     = 0;
    int miscompares = 0;

    // Truth table of the evaluator, index = {a,b,c}.
    logic [7:0] truth = 8'b1101_1110;

    // Reference model state: arbitration pointer and response register contents.
    int   m_ptr, m_id, m_cnt;
    logic m_valid, m_y;

    gate_eval_arbiter #(
        .NREQ  (NREQ),
        .ID_W  (ID_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_abc   (req_abc),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .txn_cnt   (txn_cnt)
    );

    always #5 clk = ~clk;

    always_comb rsp_word = {rsp_valid, rsp_y, rsp_id, txn_cnt};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1);
    end

    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] v, input logic rr);
        int w;
        w = winner(v, m_ptr);
        if (m_valid && !rr) return '0;
        if (w < 0) return '0;
        return NREQ'(1) << w;
    endfunction

    function automatic logic [19:0] exp_rsp();
        return {m_valid, m_y, ID_W'(m_id), CNT_W'(m_cnt)};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_id = 0; m_cnt = 0; m_valid = 1'b0; m_y = 1'b0;
    endtask

    task automatic model_clock(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] abc, input logic rr);
        int w;
        logic [2:0] ops;
        w = winner(v, m_ptr);
        if ((!m_valid || rr) && w >= 0) begin
            ops     = abc[3*w +: 3];
            m_y     = truth[ops];
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % NREQ;
            m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        end else if (rr) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] abc, input logic rr);
        req_valid = v;
        req_abc   = abc;
        rsp_ready = rr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock(req_valid, req_abc, rsp_ready);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0; req_abc = '0; rsp_ready = 1'b0; rst = 1'b0;
        #3 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (rsp_word !== 20'h0 || req_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got rsp=%h ready=%b, expected rsp=00000 ready=0000", rsp_word, req_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive('0, 12'($urandom()), 1'($urandom()));
            vectors++;
            if (req_ready !== '0) begin
                miscompares++;
                $display("FAIL idle_ready cycle %0d: got %b expected 0000", i, req_ready);
            end
            tick();
            vectors++;
            if (rsp_valid !== 1'b0 || txn_cnt !== '0) begin
                miscompares++;
                $display("FAIL idle_rsp cycle %0d: got valid=%b cnt=%0d expected valid=0 cnt=0", i, rsp_valid, txn_cnt);
            end
        end
    endtask

    task automatic test_single();
        drive(4'b0100, 12'b000_101_000_000, 1'b1);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++;
            $display("FAIL single_ready: got %b expected 0100", req_ready);
        end
        tick();
        vectors++;
        if (rsp_word !== {1'b1, 1'b0, 2'd2, 16'd1}) begin
            miscompares++;
            $display("FAIL single_rsp: got %h expected %h", rsp_word, {1'b1, 1'b0, 2'd2, 16'd1});
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_y;
        exp_y = 4'b0011;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(4'hF, 12'b000_101_010_001, 1'b1);
            vectors++;
            if (req_ready !== exp_ready(4'hF, 1'b1)) begin
                miscompares++;
                $display("FAIL rr_ready cycle %0d: got %b expected %b", i, req_ready, exp_ready(4'hF, 1'b1));
            end
            tick();
            vectors++;
            if (rsp_id !== ID_W'(i % NREQ) || rsp_y !== exp_y[i % NREQ] || rsp_word !== exp_rsp()) begin
                miscompares++;
                $display("FAIL rr_rsp cycle %0d: got id=%0d y=%b word=%h expected id=%0d y=%b word=%h",
                         i, rsp_id, rsp_y, rsp_word, i % NREQ, exp_y[i % NREQ], exp_rsp());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] v;
        for (int n = 0; n < 20; n++) begin
            drive(NREQ'($urandom_range(1, 15)), 12'($urandom()), 1'b1);
            tick();
            for (int s = 0; s < 4; s++) begin
                v = (n % 2 == 0) ? 4'hF : NREQ'($urandom_range(1, 15));
                drive(v, 12'($urandom()), (s == 3));
                vectors++;
                if (req_ready !== exp_ready(v, rsp_ready)) begin
                    miscompares++;
                    $display("FAIL bp_ready iter %0d stall %0d: got %b expected %b", n, s, req_ready, exp_ready(v, rsp_ready));
                end
                tick();
                vectors++;
                if (rsp_word !== exp_rsp()) begin
                    miscompares++;
                    $display("FAIL bp_rsp iter %0d stall %0d: got %h expected %h", n, s, rsp_word, exp_rsp());
                end
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3*NREQ-1:0] abc;
        for (int lane = 0; lane < NREQ; lane++) begin
            for (int val = 0; val < 8; val++) begin
                abc = 12'($urandom());
                abc[3*lane +: 3] = 3'(val);
                drive(NREQ'(1) << lane, abc, 1'b1);
                vectors++;
                if (req_ready !== NREQ'(1) << lane) begin
                    miscompares++;
                    $display("FAIL exh_ready lane %0d val %0d: got %b expected %b", lane, val, req_ready, NREQ'(1) << lane);
                end
                tick();
                vectors++;
                if (rsp_y !== truth[val] || rsp_word !== exp_rsp()) begin
                    miscompares++;
                    $display("FAIL exh_rsp lane %0d val %0d: got y=%b word=%h expected y=%b word=%h",
                             lane, val, rsp_y, rsp_word, truth[val], exp_rsp());
                end
            end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        for (int i = 0; i < 400; i++) begin
            v = NREQ'($urandom());
            drive(v, 12'($urandom()), ($urandom_range(0, 3) != 0));
            vectors++;
            if (req_ready !== exp_ready(v, rsp_ready)) begin
                miscompares++;
                $display("FAIL rand_ready cycle %0d: got %b expected %b", i, req_ready, exp_ready(v, rsp_ready));
            end
            tick();
            vectors++;
            if (rsp_word !== exp_rsp()) begin
                miscompares++;
                $display("FAIL rand_rsp cycle %0d: got %h expected %h", i, rsp_word, exp_rsp());
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 70000 && m_cnt != (1 << CNT_W) - 1; i++) begin
            drive(4'hF, 12'($urandom()), 1'b1);
            tick();
        end
        vectors++;
        if (txn_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_max: got %0d expected 65535", txn_cnt);
        end
        drive(4'hF, 12'($urandom()), 1'b1);
        tick();
        vectors++;
        if (txn_cnt !== 16'h0000 || rsp_word !== exp_rsp()) begin
            miscompares++;
            $display("FAIL wrap_zero: got cnt=%0d word=%h expected cnt=0 word=%h", txn_cnt, rsp_word, exp_rsp());
        end
    endtask

    task automatic test_reset_mid();
        drive(4'hF, 12'($urandom()), 1'b1);
        tick();
        drive(4'hF, 12'($urandom()), 1'b0);
        tick();
        vectors++;
        if (rsp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_full: got valid=%b expected 1", rsp_valid);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || txn_cnt !== '0 || rsp_id !== '0 || rsp_y !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got word=%h expected 00000", rsp_word);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        drive(4'hF, 12'b000_000_000_001, 1'b1);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        vectors++;
        if (rsp_word !== {1'b1, 1'b1, 2'd0, 16'd1}) begin
            miscompares++;
            $display("FAIL mid_first_rsp: got %h expected %h", rsp_word, {1'b1, 1'b1, 2'd0, 16'd1});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exhaustive();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gate_eval_arbiter.md
# gate_eval_arbiter

- Shares one `gate_wire2` evaluator, y = (a | b) ^ (~b & c), among NREQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on each request port.
- Results pass through one registered response stage with backpressure, tagged with the requester index.
- Sits between the per-lane stimulus sources and the shared gate cell; it owns the cell's inputs and captures its output.

## Interface
- NREQ, 4: number of requesters; 2..16.
- ID_W, $clog2(NREQ): width of the response requester tag.
- CNT_W, 16: width of the accepted-transaction counter.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  NREQ  per-requester request valid.
- req_abc  input  3*NREQ  operands; bits [3i+2:3i] = {a,b,c} of requester i.
- req_ready  output  NREQ  one-hot grant/accept, combinational.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_y  output  1  registered evaluator result.
- rsp_id  output  ID_W  index of the requester that produced rsp_y.
- txn_cnt  output  CNT_W  count of accepted requests; wraps modulo 2^CNT_W.

## Operation
- can_accept = !rsp_valid | rsp_ready.
- Arbitration:
  - ptr (ID_W bits) names the highest-priority requester.
  - Scan order is ptr, ptr+1, … modulo NREQ.
  - The first requester with req_valid set is the winner.
- req_ready[winner] = can_accept; every other bit is 0.
  - req_ready is 0 everywhere when no request is valid or can_accept = 0.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - the winner's {a,b,c} drives the shared evaluator;
  - rsp_y <= y, rsp_id <= i, rsp_valid <= 1;
  - ptr <= (i+1) mod NREQ;
  - txn_cnt <= txn_cnt + 1.
- No accept while rsp_ready = 1: rsp_valid <= 0; rsp_y and rsp_id hold.
- Stall: rsp_valid = 1 and rsp_ready = 0 means no grant, and rsp_valid, rsp_y, rsp_id hold stable.
- ptr changes only on accept, so a stalled winner keeps priority.
- FSM, two states:
  - EMPTY: rsp_valid = 0. Accept goes to FULL; otherwise stay.
  - FULL: rsp_valid = 1.
    - rsp_ready & accept: stay FULL with new data (back-to-back).
    - rsp_ready & !accept: go to EMPTY.
    - !rsp_ready: stay.
- Evaluator truth table over {a,b,c} = 000..111: 0,1,1,1,1,0,1,1.
- Requesters may drop req_valid without a grant; no request is latched before accept.
- Reset values: rsp_valid = 0, rsp_y = 0, rsp_id = 0, ptr = 0, txn_cnt = 0, state EMPTY.
- Reset mid-operation discards any pending response.

## Timing
- Latency is 1 cycle: an accept in cycle N gives rsp_valid/rsp_y/rsp_id in cycle N+1.
- Throughput is one transaction per cycle while rsp_ready is held high.
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready.
  - Requesters must not make req_valid depend on req_ready.
- Fairness: with all NREQ requesters continuously valid and rsp_ready = 1, each is served exactly once per NREQ cycles.
- txn_cnt wrap: 2^CNT_W − 1 → 0 on the next accept, with no flag.
- Reset is asynchronous on assertion.
  - Outputs reach reset values without a clock edge.
  - First accept is possible in the first cycle after deassertion.

## Structure
- Shared package `gate_eval_pkg`:
  - FSM state enum {EMPTY, FULL};
  - a function `rr_pick(valid, ptr)` returning the winner index and a found flag.
- One sub-module, `rr_arbiter`, parameterised by NREQ: inputs valid and ptr; outputs one-hot grant and winner index.
- The existing `gate_wire2` cell is instantiated once, unmodified, as the shared evaluator.

## Test plan
- Reset then idle:
  - Stimulus: rst pulse; req_valid = 0 for 10 cycles.
  - Required: rsp_valid = 0, req_ready = 0, txn_cnt = 0 throughout.
- Single request:
  - Stimulus: req_valid = 4'b0100, lane 2 {a,b,c} = 101, rsp_ready = 1.
  - Required: req_ready = 4'b0100; next cycle rsp_valid = 1, rsp_y = 0, rsp_id = 2, txn_cnt = 1.
- Round-robin:
  - Stimulus: all four valid, operands 001/010/101/000, rsp_ready = 1.
  - Required: rsp_id sequence 0,1,2,3,0…; rsp_y sequence 1,1,0,0.
- Backpressure:
  - Stimulus: rsp_ready = 0 for 3 cycles after a response.
  - Required: rsp_y/rsp_id held; req_ready = 0; ptr unchanged.
  - Then rsp_ready = 1: the stalled winner is granted next.
- Exhaustive:
  - Stimulus: sweep all 8 operand values on every lane.
  - Required: rsp_y matches the truth table 0,1,1,1,1,0,1,1.
- Reset mid-stream:
  - Stimulus: assert rst while FULL and rsp_ready = 0.
  - Required: rsp_valid drops immediately; after release ptr = 0, so requester 0 wins first.
